// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, line levels and parameter legality checks for the FIFO-draining UART transmitter
package uart_pkg;

    // Transmitter sequencing: pop a word, wait for the registered FIFO data, then serialise it.
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // A bit period below two clocks leaves no room for the pre-tick used to register frame_done.
    function automatic bit clks_per_bit_legal(input int value);
        return value >= 2;
    endfunction

    function automatic bit stop_bits_legal(input int value);
        return (value == 1) || (value == 2);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - read-port bundle between the synchronous FIFO and its single UART reader
//
// fifo_empty : FIFO empty flag
// fifo_data  : FIFO data_out, registered, valid the cycle after an accepted read
// fifo_r_en  : FIFO read enable, one-cycle pulse per pop
// master     : the reader (fifo_uart_tx)
// slave      : the FIFO
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_r_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_r_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_r_en
    );

endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running bit-period counter with synchronous clear
//
// clk      : system clock
// rst_n    : synchronous active-low reset
// clear    : forces the count back to 0 on the next edge
// bit_tick : high on count CLKS_PER_BIT-1 (last cycle of a bit period)
// pre_tick : high on count CLKS_PER_BIT-2 (cycle before bit_tick)
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int            CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    generate
        if (!clks_per_bit_legal(CLKS_PER_BIT)) begin : g_bad_clks_per_bit
            $error("uart_bit_timer: CLKS_PER_BIT must be 2 or more");
        end
    endgenerate

    logic [CNT_W-1:0] r_count;

    // Explicit wrap at LAST so non-power-of-two bit periods work.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bit_tick = (r_count == LAST);
    assign pre_tick = (r_count == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter that drains a synchronous FIFO one word per frame
//
// clk        : system clock
// rst_n      : synchronous active-low reset
// fifo       : FIFO read port (master side: drives r_en, reads empty/data_out)
// tx         : serial line, idles high
// busy       : high whenever the FSM is not in IDLE
// frame_done : one-cycle pulse on the last cycle of the final stop bit
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int               CNT_W     = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    generate
        if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
            $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_tx_state_t        r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_r_en;
    logic                  r_frame_done;

    logic                  w_timer_clr;
    logic                  w_bit_tick;
    logic                  w_pre_tick;
    logic [DATA_WIDTH-1:0] w_shift_next;

    // Holding the timer at 0 through the untimed states means START is always entered with a fresh count;
    // every later state boundary lands on a tick, where the timer wraps to 0 by itself.
    assign w_timer_clr  = (r_state == IDLE) || (r_state == FETCH) || (r_state == LOAD);
    assign w_shift_next = r_shift >> 1;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_timer_clr),
        .bit_tick (w_bit_tick),
        .pre_tick (w_pre_tick)
    );

    // Outputs are registered alongside the state, so each is set on the edge that enters the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_bit_cnt    <= '0;
            r_tx         <= IDLE_LEVEL;
            r_busy       <= 1'b0;
            r_r_en       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_r_en       <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= IDLE_LEVEL;
                    if (!fifo.fifo_empty) begin
                        r_state <= FETCH;
                        r_busy  <= 1'b1;
                        r_r_en  <= 1'b1;
                    end
                end
                FETCH: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    // data_out is registered in the FIFO, so it is valid only now, one cycle after the pop.
                    r_shift   <= fifo.fifo_data;
                    r_parity  <= ^fifo.fifo_data;
                    r_bit_cnt <= '0;
                    r_tx      <= START_LEVEL;
                    r_state   <= START;
                end
                START: begin
                    if (w_bit_tick) begin
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_tick) begin
                        if (r_bit_cnt == DATA_LAST) begin
                            r_bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= PARITY;
                            end else begin
                                r_tx    <= IDLE_LEVEL;
                                r_state <= STOP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= w_shift_next;
                            r_tx      <= w_shift_next[0];
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_tick) begin
                        r_tx      <= IDLE_LEVEL;
                        r_bit_cnt <= '0;
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    // pre_tick lets the registered pulse line up with the final stop cycle.
                    if (w_pre_tick && (r_bit_cnt == STOP_LAST)) begin
                        r_frame_done <= 1'b1;
                    end
                    if (w_bit_tick) begin
                        if (r_bit_cnt == STOP_LAST) begin
                            r_bit_cnt <= '0;
                            r_busy    <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= IDLE_LEVEL;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fifo.fifo_r_en = r_r_en;
    assign tx             = r_tx;
    assign busy           = r_busy;
    assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench for fifo_uart_tx across parity and stop-bit configurations
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   sel;
    int   cfg_par;
    int   cfg_stop;

    always #5 clk = ~clk;

    fifo_uart_tx_if #(.DATA_WIDTH(8)) if0 ();
    fifo_uart_tx_if #(.DATA_WIDTH(8)) if1 ();
    fifo_uart_tx_if #(.DATA_WIDTH(8)) if2 ();

    logic tx0, tx1, tx2, b0, b1, b2, fd0, fd1, fd2;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .fifo(if0), .tx(tx0), .busy(b0), .frame_done(fd0));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .fifo(if1), .tx(tx1), .busy(b1), .frame_done(fd1));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .fifo(if2), .tx(tx2), .busy(b2), .frame_done(fd2));

    logic m_tx, m_busy, m_fd, m_ren;

    always_comb begin
        m_tx = tx0; m_busy = b0; m_fd = fd0; m_ren = if0.fifo_r_en;
        case (sel)
            1: begin m_tx = tx1; m_busy = b1; m_fd = fd1; m_ren = if1.fifo_r_en; end
            2: begin m_tx = tx2; m_busy = b2; m_fd = fd2; m_ren = if2.fifo_r_en; end
            default: ;
        endcase
    end

    // FIFO model: writer owns mem/wr_cnt, reader owns rd_cnt/dout; data_out is registered.
    logic [7:0] mem [0:63];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic [7:0] dout = 8'h00;
    logic       m_empty;

    assign m_empty = (wr_cnt == rd_cnt);
    assign if0.fifo_empty = (sel != 0) || m_empty;
    assign if1.fifo_empty = (sel != 1) || m_empty;
    assign if2.fifo_empty = (sel != 2) || m_empty;
    assign if0.fifo_data  = dout;
    assign if1.fifo_data  = dout;
    assign if2.fifo_data  = dout;

    always @(posedge clk) begin
        if (m_ren && !m_empty) begin
            dout   <= mem[rd_cnt % 64];
            rd_cnt <= rd_cnt + 1;
        end
    end

    logic [7:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_cnt % 64] = d;
        wr_cnt++;
        exp_q.push_back(d);
    endtask

    // Waits for the start bit (bounded), then checks every cycle of one frame against the next expected word.
    task automatic rx_frame(input int exp_wait, input int max_wait);
        int         n;
        int         ren;
        int         fds;
        bit         seen;
        logic [7:0] want;
        n = 0; ren = 0; fds = 0; seen = 0;
        while (n < max_wait) begin
            sample();
            n++;
            if (m_ren) ren++;
            if (m_tx == 1'b0) begin
                seen = 1;
                break;
            end
        end
        check_val("start_seen", 32'(seen), 32'd1);
        if (!seen) return;
        check_val("start_latency", n, exp_wait);
        check_val("r_en_pulses", ren, 1);
        if (exp_q.size() == 0) begin
            check_val("scoreboard_nonempty", 0, 1);
            return;
        end
        want = exp_q.pop_front();
        ren = 0;
        for (int c = 1; c < CPB; c++) begin
            sample();
            check_val("start_bit", 32'(m_tx), 32'd0);
            if (m_ren) ren++;
            if (m_fd) fds++;
        end
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < CPB; c++) begin
                sample();
                check_val($sformatf("data_%02h_bit%0d", want, i), 32'(m_tx), 32'(want[i]));
                check_val("busy_in_frame", 32'(m_busy), 32'd1);
                if (m_ren) ren++;
                if (m_fd) fds++;
            end
        end
        if (cfg_par != 0) begin
            for (int c = 0; c < CPB; c++) begin
                sample();
                check_val($sformatf("parity_%02h", want), 32'(m_tx), 32'(^want));
                if (m_ren) ren++;
                if (m_fd) fds++;
            end
        end
        check_val("frame_done_early", fds, 0);
        for (int c = 0; c < cfg_stop * CPB; c++) begin
            sample();
            check_val("stop_bit", 32'(m_tx), 32'd1);
            check_val($sformatf("frame_done_stop%0d", c), 32'(m_fd), 32'(c == cfg_stop * CPB - 1));
            if (m_ren) ren++;
        end
        check_val("r_en_in_frame", ren, 0);
    endtask

    initial begin
        rst_n = 1'b0; sel = 0; cfg_par = 0; cfg_stop = 1;
        repeat (10) sample();
        check_val("rst_tx0", 32'(tx0), 32'd1);
        check_val("rst_tx1", 32'(tx1), 32'd1);
        check_val("rst_tx2", 32'(tx2), 32'd1);
        check_val("rst_busy", 32'({b0, b1, b2}), 32'd0);
        check_val("rst_fd", 32'({fd0, fd1, fd2}), 32'd0);
        check_val("rst_ren", 32'({if0.fifo_r_en, if1.fifo_r_en, if2.fifo_r_en}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            sample();
            check_val("idle_line", 32'({m_tx, m_busy, m_ren}), 32'b100);
        end

        // Single byte, no parity.
        push(8'hA5);
        rx_frame(3, 50);
        sample();
        check_val("single_busy_fall", 32'({m_busy, m_tx}), 32'b01);
        for (int i = 0; i < 10; i++) begin
            sample();
            check_val("single_no_extra_ren", 32'(m_ren), 32'd0);
        end

        // Even parity.
        sel = 1; cfg_par = 1; cfg_stop = 1;
        sample();
        push(8'h07);
        rx_frame(3, 50);
        sample();
        push(8'hA5);
        rx_frame(3, 50);
        sample();
        check_val("parity_busy_fall", 32'(m_busy), 32'd0);

        // Back-to-back drain of three preloaded words.
        sel = 0; cfg_par = 0; cfg_stop = 1;
        sample();
        push(8'h01); push(8'h80); push(8'hFF);
        rx_frame(3, 50);
        rx_frame(4, 50);
        rx_frame(4, 50);
        sample();
        check_val("b2b_busy_fall", 32'(m_busy), 32'd0);
        for (int i = 0; i < 20; i++) begin
            sample();
            check_val("b2b_no_fourth_ren", 32'(m_ren), 32'd0);
        end

        // Reset during data bit 3 of 0x3C; 0x5A must follow intact.
        push(8'h3C); push(8'h5A);
        repeat (20) sample();
        check_val("mid_bit3", 32'({m_tx, m_busy}), 32'b11);
        rst_n = 1'b0;
        sample();
        check_val("mid_rst_line", 32'({m_tx, m_busy}), 32'b10);
        for (int i = 0; i < 4; i++) begin
            check_val("mid_rst_no_ren", 32'(m_ren), 32'd0);
            sample();
        end
        void'(exp_q.pop_front());
        rst_n = 1'b1;
        rx_frame(3, 50);

        // Two stop bits.
        sel = 2; cfg_par = 0; cfg_stop = 2;
        sample();
        push(8'h55);
        rx_frame(3, 50);
        sample();
        check_val("stop2_busy_fall", 32'(m_busy), 32'd0);
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

FIFO-draining UART transmitter that sits directly downstream of the synchronous FIFO's read port. When the FIFO is non-empty it pops one word and serialises it on `tx` as a standard asynchronous frame: start bit, DATA_WIDTH data bits LSB first, optional even-parity bit, then stop bit(s). It then returns to idle and repeats until the FIFO is empty. It is the only reader of the FIFO and drives the FIFO's `r_en` directly.

## Interface
- DATA_WIDTH, 8, width of FIFO words and of the serialised data field
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range is 2 or more
- PARITY_EN, 0, when 1 an even-parity bit is inserted after the data bits
- STOP_BITS, 1, number of stop bits; legal values are 1 and 2
- Clocking: one clock `clk`; reset `rst_n` is synchronous and active-low
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  synchronous active-low reset
- fifo_empty  in  1  FIFO `empty` flag
- fifo_data  in  DATA_WIDTH  FIFO `data_out`; registered output, valid the cycle after an accepted read
- fifo_r_en  out  1  FIFO `r_en`; single-cycle pulse per pop
- tx  out  1  serial line; idles high
- busy  out  1  high whenever state is not IDLE
- frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. If fifo_empty=0, the next state is FETCH. Otherwise stay in IDLE.
- FETCH: lasts 1 cycle with fifo_r_en=1. The FIFO pops at the end of this cycle. Emptiness cannot re-assert here because this block is the only reader.
- LOAD: lasts 1 cycle with fifo_r_en=0. fifo_data is captured into the shift register and the parity accumulator (XOR of the data bits) at the end of the cycle. Next state is START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx = shift_reg[0]. Shift right every CLKS_PER_BIT cycles. The bit index runs 0..DATA_WIDTH-1. After the last bit, go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = XOR of the data bits (even parity) for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done is asserted on the final cycle. Next state is always IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1 and is cleared on every state entry. The width is $clog2(CLKS_PER_BIT); wrap-around is to 0 and never saturates.
- Bit counter: width is $clog2(DATA_WIDTH)+1. It is used for the DATA index and for the stop-bit count.
- fifo_empty is ignored in every state except IDLE.
- Writes into the FIFO during a frame have no effect on the current frame.

## Timing
- Reset values (while rst_n=0 at a rising edge): state=IDLE, tx=1, busy=0, fifo_r_en=0, frame_done=0, counters=0, shift register=0.
- Reset mid-frame: from the next cycle, tx=1 and the state is IDLE. The popped word is discarded, and no fifo_r_en is issued while rst_n=0.
- All outputs are registered or decoded from state (Moore), so fifo_r_en never depends combinationally on fifo_empty.
- Latency from fifo_empty falling to tx falling (start bit) is 3 cycles: IDLE, then FETCH, then LOAD, then START.
- Frame length in cycles, from first START cycle to last STOP cycle, is (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT.
- Inter-frame gap with a non-empty FIFO is exactly 3 cycles of tx=1 (IDLE, FETCH, LOAD), in addition to the stop bit(s).
- One fifo_r_en pulse per frame. Never two pulses within the same frame.

## Structure
- Package `uart_pkg`: state enum type `uart_tx_state_t`, localparams for IDLE_LEVEL=1 and START_LEVEL=0, and the legal-range checks for CLKS_PER_BIT and STOP_BITS.
- One sub-module, `uart_bit_timer`: parameterised CLKS_PER_BIT counter with a clear input and a `bit_tick` output on count CLKS_PER_BIT-1. The FSM, shift register and parity logic stay in the top module.
- The top module instantiates directly against the FIFO ports: fifo_r_en to `r_en`, fifo_data to `data_out`, fifo_empty to `empty`.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DATA_WIDTH=8 unless stated.
- Reset, no data: hold rst_n=0 for 10 cycles, then release with the FIFO empty. Required: tx=1, busy=0 and fifo_r_en=0 for 100 cycles.
- Single byte: write 0xA5, PARITY_EN=0. Required: exactly one fifo_r_en pulse; start bit 3 cycles after empty falls; tx bits 1,0,1,0,0,1,0,1 (4 cycles each); 4 stop cycles; frame length 40 cycles; one frame_done pulse.
- Parity: PARITY_EN=1, send 0x07 then 0xA5. Required: parity bit 1 for 0x07 and 0 for 0xA5; frame length 44 cycles.
- Back-to-back: preload 0x01, 0x80, 0xFF, then drain. Required: 3 frames in write order; exactly 3 cycles of tx=1 between each stop bit and the next start; no fourth fifo_r_en; busy falls after the final frame_done.
- Reset mid-frame: pull rst_n low during DATA bit 3 of 0x3C. Required: tx=1 and busy=0 from the next cycle. The next queued byte is transmitted intact after release.
- Two stop bits: STOP_BITS=2, send 0x55. Required: 8 stop cycles with tx=1; frame_done on the 8th stop cycle.
